tcam_search_ctrl: RTL

TCAM_SEARCH_CTRL -- requirements
Module: tcam_search_ctrl

---
 rtl/tcam_search_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/tcam_search_ctrl.sv
// TCAM search controller: holds ENTRIES rules with valid bits, presents them
// and a registered key to an external compare row, then qualifies the row's
// match vector against the valid bits and reports a prioritised result.
module tcam_search_ctrl #(
  parameter int WIDTH   = 8,
  parameter int ENTRIES = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic                       wr_inv,
  input  logic [2:0]                 wr_idx,
  input  logic [WIDTH-1:0]           wr_data,
  output logic                       wr_ready,
  input  logic                       srch_valid,
  input  logic [WIDTH-1:0]           srch_key,
  output logic                       srch_ready,
  output logic [ENTRIES*WIDTH-1:0]   rule_bus,
  output logic [WIDTH-1:0]           key_o,
  input  logic [ENTRIES-1:0]         match_i,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic                       res_hit,
  output logic [2:0]                 res_idx,
  output logic [ENTRIES-1:0]         res_vec,
  output logic [15:0]                srch_cnt,
  output logic [15:0]                hit_cnt
);

  typedef enum logic [1:0] {IDLE, APPLY, RESULT} state_t;

  state_t             state;
  logic [WIDTH-1:0]   rules [ENTRIES];
  logic [ENTRIES-1:0] valid;       // indexed by entry number
  logic [ENTRIES-1:0] valid_rev;   // valid in match_i bit order (bit 7 = entry 0)
  logic [ENTRIES-1:0] vec_next;
  logic [2:0]         idx_next;

  wire wr_accept   = (state == IDLE) && wr_en;
  wire srch_accept = (state == IDLE) && srch_valid && !wr_en;
  wire res_done    = (state == RESULT) && res_ready;

  assign wr_ready   = (state == IDLE);
  assign srch_ready = (state == IDLE) && !wr_en;
  assign res_valid  = (state == RESULT);

  // Flatten the rule store onto the compare-row bus and reverse the valid bits.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    rule_bus  = '0;
    valid_rev = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      rule_bus[WIDTH*i +: WIDTH] = rules[i];
      valid_rev[ENTRIES-1-i]     = valid[i];
    end
  end

  // Qualify the row result and pick the lowest-numbered matching entry.
  always_comb begin
    vec_next = match_i & valid_rev;
    idx_next = 3'd0;
    for (int i = ENTRIES-1; i >= 0; i--) begin
      if (vec_next[ENTRIES-1-i]) idx_next = 3'(i);
    end
  end

  // Rule store and valid bits; writes only land while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      // NOTE: the rule array is reset because rule_bus is visible at the port and must read zero.
      for (int i = 0; i < ENTRIES; i++) rules[i] <= '0;
    end else if (wr_accept) begin
      if (wr_inv) begin
        valid[wr_idx] <= 1'b0;
      end else begin
        rules[wr_idx] <= wr_data;
        valid[wr_idx] <= 1'b1;
      end
    end
  end

  // Search FSM with registered key, result and saturating counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state    <= IDLE;
      key_o    <= '0;
      res_hit  <= 1'b0;
      res_idx  <= 3'd0;
      res_vec  <= '0;
      srch_cnt <= 16'd0;
      hit_cnt  <= 16'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (srch_accept) begin
            key_o <= srch_key;
            state <= APPLY;
          end
        end
        APPLY: begin
          res_vec <= vec_next;
          res_hit <= |vec_next;
          res_idx <= idx_next;
          state   <= RESULT;
        end
        RESULT: begin
          if (res_done) begin
            if (srch_cnt != 16'hFFFF) srch_cnt <= srch_cnt + 16'd1;
            if (res_hit && hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
